// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the RAM access controller: request op-codes,
// RAM pin levels and controller states.
package ram_access_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  // rw pin levels, shared with the RAM word definitions
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    FILL,
    RESP
  } state_e;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Request/response channels between the CPU datapath and the RAM access controller.
interface ram_access_ctrl_if #(
  parameter int AW = 2,
  parameter int DW = 4
) ();

  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/ram_access_ctrl_cs_decode.sv
// Index to one-hot chip-select decoder; all zeros when disabled or index out of range.
module ram_access_ctrl_cs_decode #(
  parameter int WORDS = 4,
  parameter int AW    = 2
) (
  input  logic             en,
  input  logic [AW-1:0]    idx,
  output logic [WORDS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (en && (idx == AW'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequences word-level read/write/fill requests onto 1x4 RAM word pins
// (one-hot cs, rw, data in, shared read bus) and returns a response.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int AW    = 2,
  parameter int DW    = 4
) (
  input  logic             clk,
  input  logic             clr,
  ram_access_ctrl_if.slave bus,
  output logic [WORDS-1:0] mem_cs,
  output logic             mem_rw,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  state_e        state;
  logic [AW-1:0] cnt;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  op_e           op;
  logic [AW-1:0] req_addr;
  logic          bad_req;
  logic          dec_en;
  logic [AW-1:0] dec_idx;
  logic [WORDS-1:0] cs_next;

  assign op        = op_e'(bus.req_op);
  assign req_addr  = bus.req_addr;
  assign bad_req   = (op == OP_RSVD) || ((op != OP_FILL) && (int'(req_addr) >= WORDS));

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;

  // Chip select for the next cycle is decoded here and registered below,
  // so mem_cs is glitch-free and clears asynchronously with clr.
  always_comb begin
    dec_en  = 1'b0;
    dec_idx = '0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid && !bad_req) begin
          dec_en  = 1'b1;
          dec_idx = (op == OP_FILL) ? '0 : req_addr;
        end
      end
      FILL: begin
        if (cnt != LAST) begin
          dec_en  = 1'b1;
          dec_idx = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  ram_access_ctrl_cs_decode #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_cs_decode (
    .en     (dec_en),
    .idx    (dec_idx),
    .onehot (cs_next)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_cs    <= '0;
      mem_rw    <= RW_READ;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      mem_cs <= cs_next;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            mem_wdata <= bus.req_wdata;
            if (bad_req) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end else if (op == OP_FILL) begin
              cnt    <= '0;
              mem_rw <= RW_WRITE;
              state  <= FILL;
            end else begin
              mem_rw <= (op == OP_WRITE) ? RW_WRITE : RW_READ;
              state  <= ACCESS;
            end
          end
        end
        ACCESS: begin
          rsp_rdata <= (mem_rw == RW_READ) ? mem_rdata : '0;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          mem_rw    <= RW_READ;
          state     <= RESP;
        end
        FILL: begin
          if (cnt == LAST) begin
            mem_rw    <= RW_READ;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: RAM word model on the pins, reference memory
// with expected responses, latencies and chip-select traces.
module tb_ram_access_ctrl;
  import ram_access_ctrl_pkg::*;

  localparam int WORDS = 4;
  localparam int AW    = 2;
  localparam int DW    = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  ram_access_ctrl_if #(.AW(AW), .DW(DW)) bus ();
  logic [WORDS-1:0] mem_cs;
  logic             mem_rw;
  logic [DW-1:0]    mem_wdata;
  wire  [DW-1:0]    mem_rdata;

  ram_access_ctrl #(.WORDS(WORDS), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .mem_cs    (mem_cs),
    .mem_rw    (mem_rw),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Three-word instance for the out-of-range address path
  ram_access_ctrl_if #(.AW(AW), .DW(DW)) bus3 ();
  logic [2:0]    mem_cs3;
  logic          mem_rw3;
  logic [DW-1:0] mem_wdata3;
  wire  [DW-1:0] mem_rdata3;
  assign mem_rdata3 = ((mem_cs3 != 3'b000) && !mem_rw3) ? 4'h6 : 4'bz;

  ram_access_ctrl #(.WORDS(3), .AW(AW), .DW(DW)) dut3 (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus3),
    .mem_cs    (mem_cs3),
    .mem_rw    (mem_rw3),
    .mem_wdata (mem_wdata3),
    .mem_rdata (mem_rdata3)
  );

  // RAM words: capture on rising edge when selected for write, drive bus when selected for read
  logic [DW-1:0] ram [WORDS];
  logic          rd_en;
  logic [DW-1:0] rd_word;
  always_comb begin
    rd_en   = 1'b0;
    rd_word = '0;
    for (int i = 0; i < WORDS; i++)
      if (mem_cs[i] && !mem_rw) begin
        rd_en   = 1'b1;
        rd_word = ram[i];
      end
  end
  assign mem_rdata = rd_en ? rd_word : 4'bz;
  always @(posedge clk)
    for (int i = 0; i < WORDS; i++)
      if (mem_cs[i] && mem_rw) ram[i] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pin-activity trace: {rw, cs} for every cycle with a chip select high
  logic [WORDS:0] cs_log [$];
  always @(negedge clk) begin
    if (!clr) begin
      check("cs_onehot0", 32'($onehot0(mem_cs)), 32'd1);
      check("cs3_onehot0", 32'($onehot0(mem_cs3)), 32'd1);
      if (mem_cs != '0) cs_log.push_back({mem_rw, mem_cs});
    end
  end

  logic [DW-1:0] ref_mem [WORDS];

  task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int unsigned bp, input string tag);
    logic [DW-1:0]  exp_rd;
    logic           exp_err;
    int unsigned    exp_lat;
    logic [WORDS:0] exp_cs [$];
    int unsigned    n;
    exp_rd  = '0;
    exp_err = 1'b0;
    exp_lat = 1;
    exp_cs  = {};
    case (op)
      2'b00: begin exp_rd = ref_mem[addr]; exp_lat = 2; exp_cs.push_back({1'b0, WORDS'(1) << addr}); end
      2'b01: begin exp_lat = 2; exp_cs.push_back({1'b1, WORDS'(1) << addr}); end
      2'b10: begin
        exp_lat = WORDS + 1;
        for (int i = 0; i < WORDS; i++) exp_cs.push_back({1'b1, WORDS'(1) << i});
      end
      default: exp_err = 1'b1;
    endcase

    @(negedge clk);
    cs_log.delete();
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_accept_timeout"}, 32'(n < 20), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rd));
    check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    for (int unsigned i = 0; i < bp; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_hold_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rd));
      check({tag, "_hold_err"}, 32'(bus.rsp_err), 32'(exp_err));
      check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, "_rsp_done"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_cs_len"}, 32'(cs_log.size()), 32'(exp_cs.size()));
    if (cs_log.size() == exp_cs.size())
      for (int i = 0; i < exp_cs.size(); i++)
        check({tag, "_cs_trace"}, 32'(cs_log[i]), 32'(exp_cs[i]));

    if (op == 2'b01) ref_mem[addr] = wd;
    if (op == 2'b10) for (int i = 0; i < WORDS; i++) ref_mem[i] = wd;
  endtask

  initial begin
    logic [1:0]  rop;
    int unsigned r;

    clr            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    bus3.req_valid = 1'b0;
    bus3.req_op    = '0;
    bus3.req_addr  = '0;
    bus3.req_wdata = '0;
    bus3.rsp_ready = 1'b0;
    #1;
    check("rst_mem_cs", 32'(mem_cs), 32'd0);
    check("rst_mem_rw", 32'(mem_rw), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(negedge clk);
    clr = 1'b0;

    do_req(2'b01, 2'd0, 4'h1, 0, "init_w0");
    do_req(2'b01, 2'd1, 4'h6, 0, "init_w1");
    do_req(2'b01, 2'd3, 4'h9, 0, "init_w3");
    do_req(2'b01, 2'd2, 4'hA, 0, "write_a");
    do_req(2'b00, 2'd2, 4'h0, 0, "read_a");
    do_req(2'b11, 2'd0, 4'hF, 0, "op11");
    do_req(2'b10, 2'd0, 4'h5, 0, "fill5");
    for (int i = 0; i < WORDS; i++) do_req(2'b00, AW'(i), 4'h0, 0, "read_fill");
    do_req(2'b01, 2'd1, 4'h3, 0, "bp_write");
    do_req(2'b00, 2'd1, 4'h0, 5, "bp_read");

    // WORDS=3: address 3 is out of range, address 2 is a normal read
    @(negedge clk);
    bus3.req_op = 2'b00; bus3.req_addr = 2'd3; bus3.req_valid = 1'b1;
    check("w3_ready", 32'(bus3.req_ready), 32'd1);
    @(negedge clk);
    bus3.req_valid = 1'b0;
    check("w3_err_valid", 32'(bus3.rsp_valid), 32'd1);
    check("w3_err", 32'(bus3.rsp_err), 32'd1);
    check("w3_err_rdata", 32'(bus3.rsp_rdata), 32'd0);
    check("w3_err_cs", 32'(mem_cs3), 32'd0);
    bus3.rsp_ready = 1'b1;
    @(negedge clk);
    bus3.rsp_ready = 1'b0;
    check("w3_err_done", 32'(bus3.rsp_valid), 32'd0);
    check("w3_err_cs_after", 32'(mem_cs3), 32'd0);
    bus3.req_addr = 2'd2; bus3.req_valid = 1'b1;
    @(negedge clk);
    bus3.req_valid = 1'b0;
    check("w3_rd_cs", 32'(mem_cs3), 32'b100);
    check("w3_rd_rw", 32'(mem_rw3), 32'd0);
    @(negedge clk);
    check("w3_rd_valid", 32'(bus3.rsp_valid), 32'd1);
    check("w3_rd_rdata", 32'(bus3.rsp_rdata), 32'h6);
    check("w3_rd_err", 32'(bus3.rsp_err), 32'd0);
    bus3.rsp_ready = 1'b1;
    @(negedge clk);
    bus3.rsp_ready = 1'b0;

    for (int k = 0; k < 40; k++) begin
      r   = $urandom_range(0, 9);
      rop = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 8) ? 2'b10 : (r < 9) ? 2'b11 : 2'b00;
      do_req(rop, AW'($urandom_range(0, WORDS - 1)), DW'($urandom), $urandom_range(0, 3), "rnd");
    end

    // Reset during the second fill cycle: only word 0 has been written
    do_req(2'b01, 2'd3, 4'h9, 0, "pre_fill_w3");
    @(negedge clk);
    bus.req_op = 2'b10; bus.req_wdata = 4'hC; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 check("midfill_cs2", 32'(mem_cs), 32'b0010);
    #1 clr = 1'b1;
    #1;
    check("midfill_rst_cs", 32'(mem_cs), 32'd0);
    check("midfill_rst_rw", 32'(mem_rw), 32'd0);
    check("midfill_rst_wdata", 32'(mem_wdata), 32'd0);
    check("midfill_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("midfill_rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("midfill_rst_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    ref_mem[0] = 4'hC;
    do_req(2'b00, 2'd3, 4'h0, 0, "post_rst_r3");
    do_req(2'b00, 2'd1, 4'h0, 0, "post_rst_r1");
    do_req(2'b00, 2'd0, 4'h0, 0, "post_rst_r0");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
